vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Converts the free-running horizontal and vertical raster counts into registered VGA sync, blanking and pixel-coordinate signals for the 640x480@60 timing. Sits directly downstream of the horizontal counter and the vertical line counter (0..524, advanced once per line). Its outputs drive the pixel generator and the VGA connector pins. Also flags malformed counter sequences, so integration faults in the counter chain are caught early.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; hcnt/vcnt are valid and sampled only when high
- hcnt  in  16  horizontal count, 0..H_TOTAL-1
- vcnt  in  16  vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high inside the visible window
- x  out  10  pixel column; 0 when not visible
- y  out  10  pixel row; 0 when not visible
- line_start  out  1  one-clk pulse, sampled hcnt==0
- frame_start  out  1  one-clk pulse, sampled hcnt==0 and vcnt==0
- frame_cnt  out  16  completed-frame counter
- cnt_err  out  1  sticky counter-sequence error

## Operation
- Horizontal regions by hcnt:
  - visible: [0, H_VISIBLE)
  - front porch: [H_VISIBLE, H_VISIBLE+H_FP)
  - sync: [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC)
  - back porch: remainder
- Vertical regions: same scheme using the V_* parameters and vcnt.
- hsync = SYNC_ACTIVE in the horizontal sync region, else ~SYNC_ACTIVE. vsync likewise on vcnt.
- video_on = h visible AND v visible.
- x = hcnt[9:0] and y = vcnt[9:0] when video_on, else both 0.
- frame_cnt increments on each frame_start; wraps 65535 -> 0.
- Counter checker keeps the previous sampled (hcnt, vcnt). cnt_err sets when any of these holds:
  - hcnt >= H_TOTAL or vcnt >= V_TOTAL;
  - vcnt differs from its previous value while the previous hcnt != H_TOTAL-1;
  - previous hcnt == H_TOTAL-1 and vcnt != (prev vcnt + 1) mod V_TOTAL.
- The first sample after reset only loads the history and is not checked. cnt_err clears only on rst.
- Out-of-range counts still decode, by comparison, to non-visible, non-sync outputs.

## Timing
- All outputs are registered and update only on clk edges where pix_en=1. Latency is 1 clk from the sampling edge.
- hsync, vsync, video_on, x, y hold their values when pix_en=0.
- line_start and frame_start are high for exactly one clk, in the cycle after the sampling edge, even if pix_en stays high.
- Reset values:
  - hsync = vsync = ~SYNC_ACTIVE;
  - video_on, x, y, line_start, frame_start, frame_cnt, cnt_err = 0;
  - history invalid.
- rst takes priority over pix_en in the same cycle. Reset mid-frame returns to the reset state; decoding resumes on the next pix_en with no error raised for the discontinuity.
- frame_cnt updates in the same cycle frame_start is asserted.

## Structure
- Package vga_timing_pkg holds the 640x480 default constants, H_TOTAL/V_TOTAL derivations and the region enum (VIS, FP, SYNC, BP).
- Sub-module vga_axis_decode (count, VISIBLE/FP/SYNC/BP params) is combinational and returns region, visible and sync flags. It is instantiated once for the horizontal axis and once for the vertical axis.
- The top level contains the output registers, pulse logic, frame counter and checker.

## Test plan
- Full frame, pix_en every 4th clk, legal counts: exactly 1 frame_start and 525 line_start pulses; video_on for 307200 samples; frame_cnt=1.
- hcnt=656..751, vcnt=100: hsync=0 one clk after each sampling edge; hcnt=752 gives hsync=1. vcnt=490,491 gives vsync=0.
- hcnt=639, vcnt=479 gives x=639, y=479, video_on=1; hcnt=640 gives x=0, y=0, video_on=0.
- Inject hcnt=800, or vcnt jumping 10 -> 12 at line wrap: cnt_err=1 and stays 1 until rst.
- Assert rst at hcnt=300, vcnt=200, then resume from hcnt=301: outputs at reset values, cnt_err stays 0, frame_cnt=0.
- Run 65536 short frames by forcing the frame_start condition repeatedly: frame_cnt wraps to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and raster region type
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        VIS  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } region_e;

    function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_decode.sv
// rtl/vga_axis_decode.sv - combinational region decoder for one raster axis
//   cnt      : raster count for this axis
//   region   : VIS / FP / SYNC / BP (anything past the sync region reads as BP)
//   visible  : count inside the visible window
//   in_sync  : count inside the sync pulse
//   in_range : count below the axis total
module vga_axis_decode #(
    parameter int VISIBLE = vga_timing_pkg::H_VISIBLE_DEF,
    parameter int FP      = vga_timing_pkg::H_FP_DEF,
    parameter int SYNC    = vga_timing_pkg::H_SYNC_DEF,
    parameter int BP      = vga_timing_pkg::H_BP_DEF
) (
    input  logic [15:0]              cnt,
    output vga_timing_pkg::region_e  region,
    output logic                     visible,
    output logic                     in_sync,
    output logic                     in_range
);

    // The axis parameters name the package literals, so those are referenced qualified.
    localparam logic [15:0] VIS_END   = 16'(VISIBLE);
    localparam logic [15:0] FP_END    = 16'(VISIBLE + FP);
    localparam logic [15:0] SYNC_END  = 16'(VISIBLE + FP + SYNC);
    localparam logic [15:0] TOTAL     = 16'(vga_timing_pkg::axis_total(VISIBLE, FP, SYNC, BP));

    always_comb begin
        region = vga_timing_pkg::BP;
        if (cnt < VIS_END) begin
            region = vga_timing_pkg::VIS;
        end else if (cnt < FP_END) begin
            region = vga_timing_pkg::FP;
        end else if (cnt < SYNC_END) begin
            region = vga_timing_pkg::SYNC;
        end
    end

    assign visible  = (region == vga_timing_pkg::VIS);
    assign in_sync  = (region == vga_timing_pkg::SYNC);
    assign in_range = (cnt < TOTAL);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - registered VGA sync/blank/coordinate generator with counter checker
//   clk, rst         : clock, synchronous active-high reset
//   pix_en           : pixel tick; hcnt/vcnt sampled only when high
//   hcnt, vcnt       : raster counts from the counter chain
//   hsync, vsync     : sync outputs at SYNC_ACTIVE level inside the sync regions
//   video_on, x, y   : visible flag and pixel coordinates (0 outside the window)
//   line_start       : one-clk pulse after sampling hcnt==0
//   frame_start      : one-clk pulse after sampling hcnt==0, vcnt==0
//   frame_cnt        : frame_start counter, wraps
//   cnt_err          : sticky malformed-sequence flag
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = H_VISIBLE_DEF,
    parameter int   H_FP        = H_FP_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BP        = H_BP_DEF,
    parameter int   V_VISIBLE   = V_VISIBLE_DEF,
    parameter int   V_FP        = V_FP_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BP        = V_BP_DEF,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [15:0] hcnt,
    input  logic [15:0] vcnt,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        cnt_err
);

    localparam logic [15:0] H_LAST = 16'(axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [15:0] V_LAST = 16'(axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP) - 1);

    region_e h_region, v_region;
    logic    h_visible, v_visible, h_in_sync, v_in_sync, h_in_range, v_in_range;

    vga_axis_decode #(
        .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_decode (
        .cnt(hcnt), .region(h_region), .visible(h_visible),
        .in_sync(h_in_sync), .in_range(h_in_range)
    );

    vga_axis_decode #(
        .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_decode (
        .cnt(vcnt), .region(v_region), .visible(v_visible),
        .in_sync(v_in_sync), .in_range(v_in_range)
    );

    logic        hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        cnt_err_q, cnt_err_d, hist_valid_q, hist_valid_d;
    logic [15:0] prev_h_q, prev_h_d, prev_v_q, prev_v_d;

    logic [15:0] v_expect;
    logic        seq_bad;

    // Line wrap must advance vcnt by exactly one (mod total); mid-line vcnt must hold.
    always_comb begin
        v_expect = (prev_v_q == V_LAST) ? 16'd0 : prev_v_q + 16'd1;
        seq_bad  = !h_in_range || !v_in_range
                 || ((prev_h_q != H_LAST) && (vcnt != prev_v_q))
                 || ((prev_h_q == H_LAST) && (vcnt != v_expect));
    end

    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        cnt_err_d     = cnt_err_q;
        hist_valid_d  = hist_valid_q;
        prev_h_d      = prev_h_q;
        prev_v_d      = prev_v_q;
        if (pix_en) begin
            hsync_d       = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_d       = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on_d    = h_visible && v_visible;
            x_d           = ((h_region == VIS) && (v_region == VIS)) ? hcnt[9:0] : 10'd0;
            y_d           = ((h_region == VIS) && (v_region == VIS)) ? vcnt[9:0] : 10'd0;
            line_start_d  = (hcnt == 16'd0);
            frame_start_d = (hcnt == 16'd0) && (vcnt == 16'd0);
            if (frame_start_d) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            // First sample after reset only seeds the history.
            if (hist_valid_q && seq_bad) begin
                cnt_err_d = 1'b1;
            end
            hist_valid_d = 1'b1;
            prev_h_d     = hcnt;
            prev_v_d     = vcnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            video_on_q    <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
            cnt_err_q     <= 1'b0;
            hist_valid_q  <= 1'b0;
            prev_h_q      <= 16'd0;
            prev_v_q      <= 16'd0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            cnt_err_q     <= cnt_err_d;
            hist_valid_q  <= hist_valid_d;
            prev_h_q      <= prev_h_d;
            prev_v_q      <= prev_v_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign cnt_err     = cnt_err_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen
module tb_vga_sync_gen;

    logic        clk = 1'b0;
    logic        rst, pix_en;
    logic [15:0] hcnt, vcnt;
    logic        hsync, vsync, video_on, line_start, frame_start, cnt_err;
    logic [9:0]  x, y;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt), .cnt_err(cnt_err)
    );

    typedef struct packed {
        logic        hs, vs, von;
        logic [9:0]  x, y;
        logic        ls, fs;
        logic [15:0] fc;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   seen_ls = 0;
    int   seen_fs = 0;

    // Reference model state
    logic        m_hs = 1'b1, m_vs = 1'b1, m_von = 1'b0, m_err = 1'b0, m_hv = 1'b0;
    logic [9:0]  m_x = '0, m_y = '0;
    logic [15:0] m_fc = '0;
    int          m_ph = 0, m_pv = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (h=%0d v=%0d t=%0t)", tag, got, exp, hcnt, vcnt, $time);
        end
    endtask

    task automatic step(input logic r, input logic pe, input int h, input int v, input bit chk);
        exp_t e;
        logic ls, fs, bad;
        @(negedge clk);
        rst = r; pix_en = pe; hcnt = 16'(h); vcnt = 16'(v);
        ls = 1'b0; fs = 1'b0;
        if (r) begin
            m_hs = 1'b1; m_vs = 1'b1; m_von = 1'b0; m_x = '0; m_y = '0;
            m_fc = '0; m_err = 1'b0; m_hv = 1'b0;
        end else if (pe) begin
            m_hs  = !(h >= 656 && h <= 751);
            m_vs  = !(v == 490 || v == 491);
            m_von = (h <= 639) && (v <= 479);
            m_x   = m_von ? 10'(h) : 10'd0;
            m_y   = m_von ? 10'(v) : 10'd0;
            ls    = (h == 0);
            fs    = (h == 0) && (v == 0);
            if (fs) m_fc = m_fc + 16'd1;
            if (m_hv) begin
                bad = (h > 799) || (v > 524);
                if (m_ph == 799) bad = bad || (v != ((m_pv + 1) % 525));
                else             bad = bad || (v != m_pv);
                if (bad) m_err = 1'b1;
            end
            m_hv = 1'b1; m_ph = h; m_pv = v;
        end
        e = '{hs: m_hs, vs: m_vs, von: m_von, x: m_x, y: m_y, ls: ls, fs: fs, fc: m_fc, err: m_err};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (chk) begin
            check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (chk) begin
                check_eq("hsync", 32'(hsync), 32'(e.hs));
                check_eq("vsync", 32'(vsync), 32'(e.vs));
                check_eq("video_on", 32'(video_on), 32'(e.von));
                check_eq("x", 32'(x), 32'(e.x));
                check_eq("y", 32'(y), 32'(e.y));
                check_eq("line_start", 32'(line_start), 32'(e.ls));
                check_eq("frame_start", 32'(frame_start), 32'(e.fs));
                check_eq("frame_cnt", 32'(frame_cnt), 32'(e.fc));
                check_eq("cnt_err", 32'(cnt_err), 32'(e.err));
            end
        end
        seen_ls += int'(line_start);
        seen_fs += int'(frame_start);
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; hcnt = '0; vcnt = '0;

        // Reset state, and reset winning over pix_en
        step(1, 0, 0, 0, 1);
        step(1, 1, 5, 5, 1);

        // One full line plus line wrap, pix_en every 4th clk, junk counts between ticks
        seen_ls = 0; seen_fs = 0;
        for (int h = 0; h < 800; h++) begin
            step(0, 1, h, 100, 1);
            for (int k = 0; k < 3; k++) step(0, 0, $urandom_range(0, 900), $urandom_range(0, 600), 1);
        end
        for (int h = 0; h < 4; h++) step(0, 1, h, 101, 1);
        check_eq("line_pulses", 32'(seen_ls), 32'd2);
        check_eq("frame_pulses", 32'(seen_fs), 32'd0);

        // Visible window corner
        step(1, 0, 0, 0, 1);
        for (int h = 637; h <= 641; h++) step(0, 1, h, 479, 1);

        // Vertical sync lines 490..491
        step(1, 0, 0, 0, 1);
        step(0, 1, 799, 489, 1);
        for (int v = 490; v <= 491; v++)
            for (int h = 0; h < 800; h++) step(0, 1, h, v, 1);
        for (int h = 0; h < 3; h++) step(0, 1, h, 492, 1);

        // Frame wrap 524 -> 0
        step(1, 0, 0, 0, 1);
        seen_fs = 0;
        for (int h = 797; h < 800; h++) step(0, 1, h, 524, 1);
        for (int h = 0; h < 3; h++) step(0, 1, h, 0, 1);
        check_eq("wrap_frame_pulses", 32'(seen_fs), 32'd1);

        // vcnt jumps 10 -> 12 at line wrap; error is sticky until rst
        step(1, 0, 0, 0, 1);
        step(0, 1, 798, 10, 1);
        step(0, 1, 799, 10, 1);
        for (int h = 0; h < 3; h++) step(0, 1, h, 12, 1);
        step(0, 0, 3, 12, 1);
        step(1, 0, 0, 0, 1);

        // Out-of-range hcnt
        step(0, 1, 5, 5, 1);
        step(0, 1, 800, 5, 1);
        step(0, 1, 6, 5, 1);

        // Reset mid-frame, resume with no error for the discontinuity
        step(1, 0, 0, 0, 1);
        step(0, 1, 298, 200, 1);
        step(0, 1, 299, 200, 1);
        step(1, 1, 300, 200, 1);
        for (int h = 301; h < 306; h++) step(0, 1, h, 200, 1);

        // 65536 forced frame starts: frame_cnt wraps to 0
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 65536; i++) step(0, 1, 0, 0, i >= 65533);
        step(0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
